// File: rtl/game_sequencer.sv
// Turn controller for two-player Bulls & Cows: captures both secrets, alternates guesses,
// runs the scorer handshake, holds each score for display and declares a win or a draw.
module game_sequencer #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int MAX_ROUNDS  = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        confirm_i,
    input  logic [15:0] sw_i,
    output logic        cmp_start_o,
    output logic [15:0] cmp_secret_o,
    output logic [15:0] cmp_guess_o,
    input  logic        cmp_done_i,
    input  logic [2:0]  cmp_bulls_i,
    input  logic [2:0]  cmp_cows_i,
    output logic [2:0]  phase_o,
    output logic        player_o,
    output logic [2:0]  bulls_o,
    output logic [2:0]  cows_o,
    output logic [3:0]  round_o,
    output logic        code_err_o,
    output logic        winner_o
);

    localparam logic [2:0] PH_SECRET_J1  = 3'd0;
    localparam logic [2:0] PH_SECRET_J2  = 3'd1;
    localparam logic [2:0] PH_GUESS      = 3'd2;
    localparam logic [2:0] PH_WAIT_SCORE = 3'd3;
    localparam logic [2:0] PH_SHOW       = 3'd4;
    localparam logic [2:0] PH_WIN        = 3'd5;
    localparam logic [2:0] PH_DRAW       = 3'd6;

    // The timer only ever holds HOLD_CYCLES-1 down to 0.
    localparam int             TW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0]  HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
    localparam logic [3:0]     LAST_ROUND = 4'(MAX_ROUNDS - 1);

    logic [2:0]    phase_q, phase_d;
    logic          player_q, player_d;
    logic [15:0]   secret_j1_q, secret_j1_d;
    logic [15:0]   secret_j2_q, secret_j2_d;
    logic [15:0]   cmp_secret_q, cmp_secret_d;
    logic [15:0]   cmp_guess_q, cmp_guess_d;
    logic          cmp_start_q, cmp_start_d;
    logic [2:0]    bulls_q, bulls_d;
    logic [2:0]    cows_q, cows_d;
    logic [3:0]    round_q, round_d;
    logic          code_err_q, code_err_d;
    logic          winner_q, winner_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          sw_ok;

    function automatic logic code_ok(input logic [15:0] c);
        logic ok;
        ok = (c[15:12] <= 4'd9) && (c[11:8] <= 4'd9) && (c[7:4] <= 4'd9) && (c[3:0] <= 4'd9);
        ok = ok && (c[15:12] != c[11:8]) && (c[15:12] != c[7:4]) && (c[15:12] != c[3:0]);
        ok = ok && (c[11:8] != c[7:4]) && (c[11:8] != c[3:0]) && (c[7:4] != c[3:0]);
        return ok;
    endfunction

    assign sw_ok = code_ok(sw_i);

    always_comb begin
        phase_d      = phase_q;
        player_d     = player_q;
        secret_j1_d  = secret_j1_q;
        secret_j2_d  = secret_j2_q;
        cmp_secret_d = cmp_secret_q;
        cmp_guess_d  = cmp_guess_q;
        cmp_start_d  = 1'b0;
        bulls_d      = bulls_q;
        cows_d       = cows_q;
        round_d      = round_q;
        code_err_d   = 1'b0;
        winner_d     = winner_q;
        timer_d      = timer_q;
        case (phase_q)
            PH_SECRET_J1: if (confirm_i) begin
                if (sw_ok) begin
                    secret_j1_d = sw_i;
                    phase_d     = PH_SECRET_J2;
                end else begin
                    code_err_d = 1'b1;
                end
            end
            PH_SECRET_J2: if (confirm_i) begin
                if (sw_ok) begin
                    secret_j2_d = sw_i;
                    player_d    = 1'b0;
                    phase_d     = PH_GUESS;
                end else begin
                    code_err_d = 1'b1;
                end
            end
            PH_GUESS: if (confirm_i) begin
                if (sw_ok) begin
                    // Each player attacks the opponent's secret.
                    cmp_guess_d  = sw_i;
                    cmp_secret_d = player_q ? secret_j1_q : secret_j2_q;
                    cmp_start_d  = 1'b1;
                    phase_d      = PH_WAIT_SCORE;
                end else begin
                    code_err_d = 1'b1;
                end
            end
            PH_WAIT_SCORE: if (cmp_done_i) begin
                bulls_d = cmp_bulls_i;
                cows_d  = cmp_cows_i;
                timer_d = HOLD_LOAD;
                phase_d = PH_SHOW;
            end
            PH_SHOW: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (bulls_q == 3'd4) begin
                    winner_d = player_q;
                    phase_d  = PH_WIN;
                end else if (player_q && (round_q == LAST_ROUND)) begin
                    round_d = round_q + 4'd1;
                    phase_d = PH_DRAW;
                end else if (player_q) begin
                    round_d  = round_q + 4'd1;
                    player_d = 1'b0;
                    phase_d  = PH_GUESS;
                end else begin
                    player_d = 1'b1;
                    phase_d  = PH_GUESS;
                end
            end
            PH_WIN, PH_DRAW: if (confirm_i) begin
                secret_j1_d = '0;
                secret_j2_d = '0;
                round_d     = '0;
                bulls_d     = '0;
                cows_d      = '0;
                winner_d    = 1'b0;
                player_d    = 1'b0;
                phase_d     = PH_SECRET_J1;
            end
            default: phase_d = PH_SECRET_J1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q      <= PH_SECRET_J1;
            player_q     <= 1'b0;
            secret_j1_q  <= '0;
            secret_j2_q  <= '0;
            cmp_secret_q <= '0;
            cmp_guess_q  <= '0;
            cmp_start_q  <= 1'b0;
            bulls_q      <= '0;
            cows_q       <= '0;
            round_q      <= '0;
            code_err_q   <= 1'b0;
            winner_q     <= 1'b0;
            timer_q      <= '0;
        end else begin
            phase_q      <= phase_d;
            player_q     <= player_d;
            secret_j1_q  <= secret_j1_d;
            secret_j2_q  <= secret_j2_d;
            cmp_secret_q <= cmp_secret_d;
            cmp_guess_q  <= cmp_guess_d;
            cmp_start_q  <= cmp_start_d;
            bulls_q      <= bulls_d;
            cows_q       <= cows_d;
            round_q      <= round_d;
            code_err_q   <= code_err_d;
            winner_q     <= winner_d;
            timer_q      <= timer_d;
        end
    end

    assign phase_o      = phase_q;
    assign player_o     = player_q;
    assign cmp_start_o  = cmp_start_q;
    assign cmp_secret_o = cmp_secret_q;
    assign cmp_guess_o  = cmp_guess_q;
    assign bulls_o      = bulls_q;
    assign cows_o       = cows_q;
    assign round_o      = round_q;
    assign code_err_o   = code_err_q;
    assign winner_o     = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected observable events,
// a monitor pops one per event (pulse or state change) and compares.
module tb_game_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        confirm_i = 1'b0;
    logic [15:0] sw_i = '0;
    logic        cmp_done_i = 1'b0;
    logic [2:0]  cmp_bulls_i = '0;
    logic [2:0]  cmp_cows_i = '0;
    logic        cmp_start_o;
    logic [15:0] cmp_secret_o;
    logic [15:0] cmp_guess_o;
    logic [2:0]  phase_o;
    logic        player_o;
    logic [2:0]  bulls_o;
    logic [2:0]  cows_o;
    logic [3:0]  round_o;
    logic        code_err_o;
    logic        winner_o;

    game_sequencer #(.HOLD_CYCLES(4), .MAX_ROUNDS(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .confirm_i(confirm_i), .sw_i(sw_i),
        .cmp_start_o(cmp_start_o), .cmp_secret_o(cmp_secret_o), .cmp_guess_o(cmp_guess_o),
        .cmp_done_i(cmp_done_i), .cmp_bulls_i(cmp_bulls_i), .cmp_cows_i(cmp_cows_i),
        .phase_o(phase_o), .player_o(player_o), .bulls_o(bulls_o), .cows_o(cows_o),
        .round_o(round_o), .code_err_o(code_err_o), .winner_o(winner_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          ph, pl, b, c, r, w, err, st;
        bit          chk_cmp;
        logic [15:0] sec, gs;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   ev_idx = 0;

    task automatic push(input int ph, pl, b, c, r, w, err, st, input bit chk_cmp,
                        input logic [15:0] sec, gs, input int gap);
        exp_t e;
        e.ph = ph; e.pl = pl; e.b = b; e.c = c; e.r = r; e.w = w; e.err = err; e.st = st;
        e.chk_cmp = chk_cmp; e.sec = sec; e.gs = gs; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL ev%0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    // Monitor: one event per cycle with a pulse or any change in the held outputs.
    initial begin : monitor
        logic [14:0] prev;
        logic [14:0] snap;
        exp_t        e;
        prev = '1;
        forever begin
            @(negedge clk_i);
            cyc++;
            snap = {phase_o, player_o, bulls_o, cows_o, round_o, winner_o};
            if (code_err_o || cmp_start_o || (snap != prev)) begin
                prev = snap;
                ev_idx++;
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL ev%0d unexpected_event: got phase %0d start %0d err %0d expected none",
                             ev_idx, phase_o, cmp_start_o, code_err_o);
                end else begin
                    e = q.pop_front();
                    chk("phase", ev_idx, int'(phase_o), e.ph);
                    chk("player", ev_idx, int'(player_o), e.pl);
                    chk("bulls", ev_idx, int'(bulls_o), e.b);
                    chk("cows", ev_idx, int'(cows_o), e.c);
                    chk("round", ev_idx, int'(round_o), e.r);
                    chk("winner", ev_idx, int'(winner_o), e.w);
                    chk("code_err", ev_idx, int'(code_err_o), e.err);
                    chk("cmp_start", ev_idx, int'(cmp_start_o), e.st);
                    if (e.chk_cmp) begin
                        chk("cmp_secret", ev_idx, int'(cmp_secret_o), int'(e.sec));
                        chk("cmp_guess", ev_idx, int'(cmp_guess_o), int'(e.gs));
                    end
                    if (e.gap >= 0) chk("gap", ev_idx, cyc - last_cyc, e.gap);
                    $display("ev%0d cyc %0d phase %0d player %0d b %0d c %0d round %0d win %0d",
                             ev_idx, cyc, phase_o, player_o, bulls_o, cows_o, round_o, winner_o);
                end
                last_cyc = cyc;
            end
        end
    end

    task automatic conf(input logic [15:0] v);
        sw_i = v;
        confirm_i = 1'b1;
        @(negedge clk_i);
        confirm_i = 1'b0;
    endtask

    task automatic done(input logic [2:0] b, input logic [2:0] c);
        cmp_bulls_i = b;
        cmp_cows_i = c;
        cmp_done_i = 1'b1;
        @(negedge clk_i);
        cmp_done_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin : stim
        // Reset state, including the scorer bus.
        push(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, -1);
        idle(2);
        rst_i = 1'b0;
        idle(1);

        // Repeated digit and non-BCD digit are rejected.
        push(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h1123);
        idle(1);
        push(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h12A4);
        idle(2);

        // Secrets, J1 guess, 2/2 score, turn passes to J2 after 4 SHOW cycles.
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h1234);
        push(2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h5678);
        push(3, 0, 0, 0, 0, 0, 0, 1, 1, 16'h5678, 16'h5687, -1);
        conf(16'h5687);
        idle(3);
        push(4, 0, 2, 2, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        push(2, 1, 2, 2, 0, 0, 0, 0, 0, 16'h0, 16'h0, 4);
        done(3'd2, 3'd2);
        idle(6);

        // J2 cracks J1's secret -> WIN, then a confirm (unchecked code) clears.
        push(3, 1, 2, 2, 0, 0, 0, 1, 1, 16'h1234, 16'h1234, -1);
        conf(16'h1234);
        idle(2);
        push(4, 1, 4, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        push(5, 1, 4, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 4);
        done(3'd4, 3'd0);
        idle(6);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'hFFFF);
        idle(2);

        // Two full rounds without a win -> DRAW; stray confirms are dropped.
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h1357);
        push(2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h2468);
        push(3, 0, 0, 0, 0, 0, 0, 1, 1, 16'h2468, 16'h2486, -1);
        conf(16'h2486);
        idle(1);
        conf(16'h9876);
        idle(1);
        push(4, 0, 1, 3, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        push(2, 1, 1, 3, 0, 0, 0, 0, 0, 16'h0, 16'h0, 4);
        done(3'd1, 3'd3);
        conf(16'h9876);
        idle(5);
        push(3, 1, 1, 3, 0, 0, 0, 1, 1, 16'h1357, 16'h1375, -1);
        conf(16'h1375);
        idle(1);
        push(4, 1, 2, 2, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        push(2, 0, 2, 2, 1, 0, 0, 0, 0, 16'h0, 16'h0, 4);
        done(3'd2, 3'd2);
        idle(6);
        push(3, 0, 2, 2, 1, 0, 0, 1, 1, 16'h2468, 16'h8642, -1);
        conf(16'h8642);
        idle(1);
        push(4, 0, 0, 4, 1, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        push(2, 1, 0, 4, 1, 0, 0, 0, 0, 16'h0, 16'h0, 4);
        done(3'd0, 3'd4);
        idle(6);
        push(3, 1, 0, 4, 1, 0, 0, 1, 1, 16'h1357, 16'h7531, -1);
        conf(16'h7531);
        idle(1);
        // Out-of-range 5 bulls is latched as-is and is not a win.
        push(4, 1, 5, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        push(6, 1, 5, 0, 2, 0, 0, 0, 0, 16'h0, 16'h0, 4);
        done(3'd5, 3'd0);
        idle(6);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h1234);
        idle(2);

        // Reset mid-handshake; a late cmp_done must be ignored.
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h1234);
        push(2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h5678);
        push(3, 0, 0, 0, 0, 0, 0, 1, 1, 16'h5678, 16'h1243, -1);
        conf(16'h1243);
        idle(1);
        push(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, -1);
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(1);
        done(3'd4, 3'd0);
        idle(6);

        // Confirm and cmp_done together in WAIT_SCORE: score wins, confirm dropped.
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h1234);
        push(2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        conf(16'h5678);
        push(3, 0, 0, 0, 0, 0, 0, 1, 1, 16'h5678, 16'h5768, -1);
        conf(16'h5768);
        idle(1);
        push(4, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0, -1);
        push(2, 1, 1, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 4);
        sw_i = 16'h9012;
        confirm_i = 1'b1;
        done(3'd1, 3'd1);
        confirm_i = 1'b0;
        idle(10);

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d outstanding expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
